// File: rtl/decoder_scan_n.sv
// Registered N-to-2**N active-low decoder with 74-style enable gate and a prescaled auto-scan mode.
// Defining DEC_DEADTIME_EN blanks y during each scan step cycle (ghosting suppression); requires DIV >= 2.
module decoder_scan_n #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           g1,
  input  logic           g2a,
  input  logic           g2b,
  input  logic           mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   last,
  output logic [2**N-1:0] y,
  output logic [N-1:0]   idx,
  output logic           tick
);

  localparam int W  = 2 ** N;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [W-1:0]  ONE_HOT0 = {{(W-1){1'b0}}, 1'b1};

`ifdef DEC_DEADTIME_EN
  localparam bit DEADTIME = 1'b1;
`else
  localparam bit DEADTIME = 1'b0;
`endif

  logic          en;
  logic          mode_q;
  logic [CW-1:0] cnt, cnt_next;
  logic [N-1:0]  idx_next;
  logic          tick_next;
  logic [W-1:0]  y_next;

  assign en = g1 & ~g2a & ~g2b;

  // mode_q lets the first scan edge after leaving direct mode restart the prescaler in place
  always_comb begin
    cnt_next  = cnt;
    idx_next  = idx;
    tick_next = 1'b0;
    if (!mode) begin
      cnt_next = '0;
      idx_next = a;
    end else if (!mode_q) begin
      cnt_next = '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_next  = '0;
        idx_next  = (idx >= last) ? '0 : idx + 1'b1;
        tick_next = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end

    y_next = en ? ~(ONE_HOT0 << idx_next) : '1;
    if (DEADTIME && mode && tick_next) begin
      y_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y      <= '1;
      idx    <= '0;
      tick   <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      y      <= y_next;
      idx    <= idx_next;
      tick   <= tick_next;
      cnt    <= cnt_next;
      mode_q <= mode;
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_decoder_scan_n;

  localparam int N   = 3;
  localparam int DIV = 4;
  localparam int W   = 2 ** N;

  typedef struct {
    logic [W-1:0] y;
    logic [N-1:0] idx;
    logic         tick;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         g1 = 1'b0, g2a = 1'b0, g2b = 1'b0, mode = 1'b0;
  logic [N-1:0] a = '0, last = '0;
  logic [W-1:0] y;
  logic [N-1:0] idx;
  logic         tick;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference state: plain integers following the behavioural rules
  int m_idx = 0, m_phase = 0, m_tick = 0, m_scanning = 0;

  decoder_scan_n #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b),
    .mode(mode), .a(a), .last(last), .y(y), .idx(idx), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input bit r, input bit e1, input bit e2a, input bit e2b,
                               input bit md, input int av, input int lv);
    exp_t e;
    bit   en;
    @(negedge clk);
    rst = r; g1 = e1; g2a = e2a; g2b = e2b; mode = md;
    a = N'(av); last = N'(lv);
    en = e1 && !e2a && !e2b;
    if (r) begin
      m_idx = 0; m_phase = 0; m_tick = 0; m_scanning = 0;
    end else begin
      m_tick = 0;
      if (!md) begin
        m_idx = av; m_phase = 0;
      end else if (!m_scanning) begin
        m_phase = 0;
      end else if (en) begin
        m_phase = m_phase + 1;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_tick  = 1;
          m_idx   = (m_idx >= lv) ? 0 : m_idx + 1;
        end
      end
      m_scanning = md;
    end
    e.idx  = N'(m_idx);
    e.tick = (m_tick != 0);
    e.y    = (!r && en) ? W'(~(64'd1 << m_idx)) : {W{1'b1}};
`ifdef DEC_DEADTIME_EN
    if (!r && md && m_tick != 0) e.y = {W{1'b1}};
`endif
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (y !== e.y || idx !== e.idx || tick !== e.tick) begin
      errors++;
      $display("[TB] FAIL outputs @%0t: got y=%h idx=%0d tick=%b, want y=%h idx=%0d tick=%b",
               $time, y, idx, tick, e.y, e.idx, e.tick);
    end
  endtask

  // monitor: the DUT presents a registered output every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    int rl;
    $display("[TB] start N=%0d DIV=%0d", N, DIV);
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) applyStimulus(0, 1, 0, 0, 0, i, 0);
    applyStimulus(0, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, 1, 0, 0, 0, 5, 0);
    applyStimulus(0, 1, 1, 0, 0, 5, 0);
    applyStimulus(0, 1, 0, 0, 0, 5, 0);
    applyStimulus(0, 1, 0, 1, 0, 5, 0);
    applyStimulus(0, 1, 0, 0, 0, 5, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    // scan wrap at last=2, then pause and lower last
    for (int i = 0; i < 22; i++) applyStimulus(0, 1, 0, 0, 1, 0, 2);
    for (int i = 0; i < 5; i++)  applyStimulus(0, 0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 1, 0, 1);
    // last=0 and a run to idx=3 followed by reset mid-scan
    for (int i = 0; i < 9; i++)  applyStimulus(0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 3, 7);
    for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 0, 1, 0, 7);
    applyStimulus(1, 1, 0, 0, 1, 0, 7);
    for (int i = 0; i < 6; i++)  applyStimulus(0, 1, 0, 0, 1, 0, 7);
    applyStimulus(0, 1, 0, 0, 0, 6, 7);
    applyStimulus(0, 1, 0, 0, 0, 6, 7);
    // randomized traffic, mostly enabled scanning with occasional mode/last changes
    rl = 7;
    for (int i = 0; i < 400; i++) begin
      bit r, e1, e2a, e2b, md;
      r   = ($urandom_range(0, 99) == 0);
      e1  = ($urandom_range(0, 9) != 0);
      e2a = ($urandom_range(0, 14) == 0);
      e2b = ($urandom_range(0, 14) == 0);
      md  = ((i / 50) % 3) != 1;
      if ($urandom_range(0, 19) == 0) rl = $urandom_range(0, W - 1);
      applyStimulus(r, e1, e2a, e2b, md, $urandom_range(0, W - 1), rl);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
Parametrised, registered successor to the 3-to-8 74-series decoder. It decodes an N-bit index to 2**N active-low select lines behind the same three-input enable gate (g1, g2a, g2b). It adds a self-running scan mode: a prescaled counter steps the index from 0 up to a programmable last channel and wraps. It sits between the control logic and multiplexed displays or strobed peripherals (digit/row select).

Parameters:
N, 3, select width; outputs = 2**N; legal range 1..6.
DIV, 4, clk cycles per scan step; legal range 1..65535 (2..65535 when DEC_DEADTIME_EN is defined).

Ports:
clk   in   1       system clock, all state on rising edge
rst   in   1       synchronous reset, active-high
g1    in   1       enable, active-high
g2a   in   1       enable, active-low
g2b   in   1       enable, active-low
mode  in   1       0 = direct decode of a; 1 = auto-scan
a     in   N       direct-mode index
last  in   N       scan-mode highest channel (wrap point)
y     out  2**N    registered active-low one-hot select
idx   out  N       registered current index
tick  out  1       one-cycle pulse, high in the cycle idx advances in scan mode

Behaviour:
- Definition: en = g1 & ~g2a & ~g2b, sampled each clk edge.
- Reset:
  - rst is synchronous and active-high, and has priority over all other inputs.
  - Reset values: y = all ones, idx = 0, tick = 0, prescaler cnt = 0.
- Registered output:
  - y(next) = en ? ~(1 << idx(next)) : all ones.
  - Exactly one y bit is low whenever en was high at the previous edge.
- Direct mode (mode = 0):
  - idx <= a; latency from a to y is 1 cycle.
  - cnt is held at 0; tick = 0.
  - en gates y only; idx still tracks a while disabled.
- Scan mode (mode = 1):
  - Prescaler cnt, width max(1, clog2(DIV)), counts 0..DIV-1 only while en = 1.
  - When en = 1 and cnt == DIV-1:
    - cnt <= 0.
    - idx <= (idx >= last) ? 0 : idx + 1.
    - tick <= 1.
  - Otherwise cnt <= cnt + 1 (when en = 1), tick <= 0, and idx holds.
  - When en = 0: cnt and idx hold, tick = 0, y = all ones. Scanning resumes in place when en returns.
  - DIV = 1: idx advances every enabled cycle; tick stays high continuously.
  - last = 0: idx is held at 0, but tick still pulses every DIV cycles.
  - last lowered below the current idx: the next step wraps to 0. No out-of-range value is ever produced.
- Mode changes:
  - 0 -> 1: cnt <= 0; scanning starts from the current idx (the last value of a).
  - 1 -> 0: cnt <= 0, tick <= 0; idx <= a on the same edge.
- Mid-operation reset: on the edge where rst = 1, all state returns to reset values regardless of mode, en or cnt.

Optional Feature:
- Macro: DEC_DEADTIME_EN (ghosting suppression).
- Defined:
  - In scan mode, y is forced to all ones during the cycle in which tick = 1. The new one-hot value appears one cycle later.
  - Each channel is therefore active for DIV-1 of every DIV cycles.
  - DIV must be >= 2; the legal range for DIV becomes 2..65535.
  - Direct mode is unaffected.
- Not defined: y switches directly from the old one-hot value to the new one with no gap.

Test Plan:
(All cases use N=3, DIV=4 unless stated.)
1. Reset and direct decode: assert rst for 2 cycles -> y=8'hFF, idx=0, tick=0. Then release rst with g1=1, g2a=0, g2b=0, mode=0 and sweep a = 0..7 -> one cycle after each a, y = FE, FD, FB, F7, EF, DF, BF, 7F.
2. Enable gating: in direct mode with a=5, toggle each of g1=0, g2a=1, g2b=1 in turn -> y=FF the next cycle. Restore the enables -> y=DF.
3. Scan wrap: set mode=1, last=2, starting from idx=0 -> idx sequence 0,1,2,0,1, each value held for 4 cycles. tick pulses once every 4 cycles. y cycles FE, FD, FB.
4. Pause and lower last: during a scan at idx=2, set cnt=1, then en=0 for 5 cycles -> y=FF while disabled, and idx and cnt are frozen. Re-enable and set last=1 -> idx goes 2 -> 0 at the next step.
5. Reset mid-scan and mode switch: assert rst at cnt=2, idx=3 -> next cycle all reset values. Switch mode 1 -> 0 with a=6 -> y=BF one cycle later and tick=0.
6. DEC_DEADTIME_EN defined, scan mode, last=7 -> at each tick cycle y=FF, and the new one-hot value appears one cycle later. Each channel is low for exactly 3 of every 4 cycles.
